// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: shared RV32I encoding definitions for the instruction encoder.
//   - K_* instruction-class codes carried on in_kind (LOAD=0 .. JAL=8)
//   - OPC_* 7-bit major opcodes
//   - fmt_e   : instruction format (R/I/S/B/U/J)
//   - state_e : encoder control states
//   - decode_kind() maps a class code to opcode + format
//   - fits_signed() range helper used by the optional field checks
package rv_isa_pkg;

  localparam logic [3:0] K_LOAD   = 4'd0;
  localparam logic [3:0] K_OPIMM  = 4'd1;
  localparam logic [3:0] K_AUIPC  = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_OP     = 4'd4;
  localparam logic [3:0] K_LUI    = 4'd5;
  localparam logic [3:0] K_BRANCH = 4'd6;
  localparam logic [3:0] K_JALR   = 4'd7;
  localparam logic [3:0] K_JAL    = 4'd8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [6:0] opcode;
    fmt_e       fmt;
  } kind_info_t;

  // Unknown classes map to opcode 0 / R format so they carry no immediate.
  function automatic kind_info_t decode_kind(input logic [3:0] kind);
    kind_info_t info;
    info.opcode = 7'b0000000;
    info.fmt    = FMT_R;
    case (kind)
      K_LOAD:   begin info.opcode = OPC_LOAD;   info.fmt = FMT_I; end
      K_OPIMM:  begin info.opcode = OPC_OPIMM;  info.fmt = FMT_I; end
      K_AUIPC:  begin info.opcode = OPC_AUIPC;  info.fmt = FMT_U; end
      K_STORE:  begin info.opcode = OPC_STORE;  info.fmt = FMT_S; end
      K_OP:     begin info.opcode = OPC_OP;     info.fmt = FMT_R; end
      K_LUI:    begin info.opcode = OPC_LUI;    info.fmt = FMT_U; end
      K_BRANCH: begin info.opcode = OPC_BRANCH; info.fmt = FMT_B; end
      K_JALR:   begin info.opcode = OPC_JALR;   info.fmt = FMT_I; end
      K_JAL:    begin info.opcode = OPC_JAL;    info.fmt = FMT_J; end
      default:  ;
    endcase
    return info;
  endfunction

  function automatic logic kind_known(input logic [3:0] kind);
    return kind <= K_JAL;
  endfunction

  // v is representable as a width-bit two's-complement value when every bit
  // from width-1 upward equals the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned width);
    logic [31:0] ext;
    ext = $unsigned($signed(v) >>> (width - 1));
    return (ext == '0) || (ext == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-beat input stream and encoded-word output stream.
//   in_valid/in_ready/in_last + decoded fields : sequencer -> encoder
//   out_valid/out_ready/out_instr/out_addr     : encoder -> instruction memory
// Modports:
//   slave  : the encoder (consumes beats, produces words)
//   master : the environment (produces beats, consumes words)
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport slave (
    input  in_valid, in_last, in_kind, in_funct3, in_funct7b5,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_last, in_kind, in_funct3, in_funct7b5,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: combinational placement of an unshifted immediate into the
// instruction-word bit positions of the given format. All non-immediate
// bits are returned as zero so the caller can OR in the other fields.
//   fmt_i  : instruction format
//   imm_i  : byte offset / value (U-type: full 32-bit value)
//   bits_o : immediate bits in machine-word position
module imm_pack
  import rv_isa_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] bits_o
);

  always_comb begin
    bits_o = '0;
    unique case (fmt_i)
      FMT_I: bits_o[31:20] = imm_i[11:0];
      FMT_S: begin
        bits_o[31:25] = imm_i[11:5];
        bits_o[11:7]  = imm_i[4:0];
      end
      FMT_B: begin
        bits_o[31]    = imm_i[12];
        bits_o[30:25] = imm_i[10:5];
        bits_o[11:8]  = imm_i[4:1];
        bits_o[7]     = imm_i[11];
      end
      FMT_U: bits_o[31:12] = imm_i[31:12];
      FMT_J: begin
        bits_o[31]    = imm_i[20];
        bits_o[30:21] = imm_i[10:1];
        bits_o[20]    = imm_i[11];
        bits_o[19:12] = imm_i[19:12];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder. Packs decoded fields into 32-bit
// machine words and emits them through a one-deep registered output stage
// with valid/ready backpressure, each tagged with an incrementing address.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : arms a new program (only honoured in IDLE)
//   bus        : instr_encoder_if.slave (field beats in, encoded words out)
//   busy       : state is not IDLE
//   done       : one-cycle pulse after the final word is accepted
//   err        : sticky illegal-field flag since start
//   count      : words emitted since start (saturating)
// Parameter BASE_ADDR: address of the first word after each start.
// Optional macro INSTR_ENCODER_CHECK_EN: enables field range checks; an
// illegal beat is emitted as 32'h0 and sets err. Without it err is 0 and
// out-of-range bits are truncated.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           count
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [15:0] count_q, count_d;
  logic        done_q, done_d;

  kind_info_t  info;
  logic [31:0] imm_bits;
  logic [31:0] word_raw;
  logic [31:0] word;
  logic        shift_op;
  logic        accept;
  logic        out_fire;

  assign info     = decode_kind(bus.in_kind);
  assign shift_op = (bus.in_kind == K_OPIMM) &&
                    ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

  imm_pack u_imm_pack (
    .fmt_i  (info.fmt),
    .imm_i  (bus.in_imm),
    .bits_o (imm_bits)
  );

  always_comb begin
    word_raw      = imm_bits;
    word_raw[6:0] = info.opcode;
    unique case (info.fmt)
      FMT_R: begin
        word_raw[11:7]  = bus.in_rd;
        word_raw[14:12] = bus.in_funct3;
        word_raw[19:15] = bus.in_rs1;
        word_raw[24:20] = bus.in_rs2;
      end
      FMT_I: begin
        word_raw[11:7]  = bus.in_rd;
        word_raw[14:12] = bus.in_funct3;
        word_raw[19:15] = bus.in_rs1;
      end
      FMT_S, FMT_B: begin
        word_raw[14:12] = bus.in_funct3;
        word_raw[19:15] = bus.in_rs1;
        word_raw[24:20] = bus.in_rs2;
      end
      FMT_U, FMT_J: word_raw[11:7] = bus.in_rd;
      default: ;
    endcase
    if ((bus.in_kind == K_OP) &&
        ((bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b101))) begin
      word_raw[30] = bus.in_funct7b5;
    end
    // Shift-immediates reuse the I layout for shamt in [24:20]; the upper
    // funct7 field is rebuilt rather than taken from imm[11:5].
    if (shift_op) begin
      word_raw[31:25] = '0;
      word_raw[30]    = bus.in_funct7b5 && (bus.in_funct3 == 3'b101);
    end
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic illegal;
  logic err_q, err_d;

  always_comb begin
    illegal = 1'b0;
    unique case (info.fmt)
      FMT_I, FMT_S: illegal = !fits_signed(bus.in_imm, 12);
      FMT_B:        illegal = !fits_signed(bus.in_imm, 13) || bus.in_imm[0];
      FMT_J:        illegal = !fits_signed(bus.in_imm, 21) || bus.in_imm[0];
      FMT_U:        illegal = (bus.in_imm[11:0] != 12'h000);
      default:      illegal = 1'b0;
    endcase
    if (!kind_known(bus.in_kind)) illegal = 1'b1;
    if (shift_op && (bus.in_imm[11:5] != 7'h00)) illegal = 1'b1;
    word = illegal ? '0 : word_raw;
  end

  always_comb begin
    err_d = err_q;
    if ((state_q == S_IDLE) && start) err_d = 1'b0;
    if (accept && illegal)            err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign word = word_raw;
  assign err  = 1'b0;
`endif

  assign bus.in_ready = (state_q == S_STREAM) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;

  // out_addr_q doubles as the address counter: it always names the word in
  // (or next entering) the output register, so it advances on each transfer.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    count_d     = count_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_STREAM;
          out_addr_d = BASE_ADDR;
          count_d    = '0;
        end
      end
      S_STREAM: begin
        if (accept && bus.in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_fire) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + 32'd4;
      if (count_q != '1) count_d = count_q + 16'd1;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign count         = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import rv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic        busy, done, err;
  logic        busy2, done2, err2;
  logic [15:0] count, count2;
  int          n_cmp = 0;
  int          n_err = 0;

  instr_encoder_if ifa ();
  instr_encoder_if ifb ();

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (ifa),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .count (count)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .bus   (ifb),
    .busy  (busy2),
    .done  (done2),
    .err   (err2),
    .count (count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] kind, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last);
    ifa.in_valid    = 1'b1;
    ifa.in_kind     = kind;
    ifa.in_funct3   = f3;
    ifa.in_funct7b5 = f7;
    ifa.in_rd       = rd;
    ifa.in_rs1      = rs1;
    ifa.in_rs2      = rs2;
    ifa.in_imm      = imm;
    ifa.in_last     = last;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.in_kind = '0; ifa.in_funct3 = '0;
    ifa.in_funct7b5 = 1'b0; ifa.in_rd = '0; ifa.in_rs1 = '0; ifa.in_rs2 = '0;
    ifa.in_imm = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.in_kind = '0; ifb.in_funct3 = '0;
    ifb.in_funct7b5 = 1'b0; ifb.in_rd = '0; ifb.in_rs1 = '0; ifb.in_rs2 = '0;
    ifb.in_imm = '0; ifb.out_ready = 1'b1;

    // Reset values
    tick(); tick();
    chk("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, ifa.in_ready},  32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_done",      {31'd0, done},          32'd0);
    chk("rst_err",       {31'd0, err},           32'd0);
    chk("rst_out_instr", ifa.out_instr,          32'h0000_0000);
    chk("rst_out_addr",  ifa.out_addr,           32'h0000_0000);
    chk("rst_count",     {16'd0, count},         32'd0);
    chk("rst_wrap_addr", ifb.out_addr,           32'hFFFF_FFFC);
    reset = 1'b0;

    // One-word program
    start = 1'b1; tick(); start = 1'b0;
    chk("p1_busy",     {31'd0, busy},         32'd1);
    chk("p1_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    beat(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    tick(); ifa.in_valid = 1'b0;
    chk("p1_out_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("p1_instr",     ifa.out_instr,          32'h0050_0093);
    chk("p1_addr",      ifa.out_addr,           32'h0000_0000);
    chk("p1_drain_rdy", {31'd0, ifa.in_ready},  32'd0);
    chk("p1_done_pre",  {31'd0, done},          32'd0);
    start = 1'b1;  // ignored while draining
    tick(); start = 1'b0;
    chk("p1_done",      {31'd0, done},          32'd1);
    chk("p1_busy_fall", {31'd0, busy},          32'd0);
    chk("p1_count",     {16'd0, count},         32'd1);
    chk("p1_valid_off", {31'd0, ifa.out_valid}, 32'd0);
    tick();
    chk("p1_done_pulse", {31'd0, done}, 32'd0);

    // Back-to-back stream, no bubbles
    start = 1'b1; tick(); start = 1'b0;
    beat(K_OP, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    tick();
    chk("s_op_instr", ifa.out_instr, 32'h4020_81B3);
    chk("s_op_addr",  ifa.out_addr,  32'h0000_0000);
    chk("s_op_ready", {31'd0, ifa.in_ready}, 32'd1);
    beat(K_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0);
    tick();
    chk("s_br_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("s_br_instr", ifa.out_instr, 32'hFE20_8CE3);
    chk("s_br_addr",  ifa.out_addr,  32'h0000_0004);
    beat(K_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0);
    tick();
    chk("s_jal_instr", ifa.out_instr, 32'h0010_00EF);
    chk("s_jal_addr",  ifa.out_addr,  32'h0000_0008);
    beat(K_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    tick(); ifa.in_valid = 1'b0;
    chk("s_lui_instr", ifa.out_instr, 32'h1234_52B7);
    chk("s_lui_addr",  ifa.out_addr,  32'h0000_000C);
    chk("s_cnt_mid",   {16'd0, count}, 32'd3);
    tick();
    chk("s_done",  {31'd0, done},  32'd1);
    chk("s_count", {16'd0, count}, 32'd4);
    tick();

    // Backpressure
    start = 1'b1; tick(); start = 1'b0;
    ifa.out_ready = 1'b0;
    beat(K_OPIMM, 3'b000, 1'b0, 5'd2, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    beat(K_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("bp_instr", ifa.out_instr, 32'hFFF0_8113);
      chk("bp_addr",  ifa.out_addr,  32'h0000_0000);
      chk("bp_ready", {31'd0, ifa.in_ready}, 32'd0);
      tick();
    end
    ifa.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'd0, ifa.in_ready}, 32'd1);
    tick(); ifa.in_valid = 1'b0;
    chk("bp_st_instr", ifa.out_instr, 32'h0020_A423);
    chk("bp_st_addr",  ifa.out_addr,  32'h0000_0004);
    chk("bp_cnt_mid",  {16'd0, count}, 32'd1);
    tick();
    chk("bp_done",  {31'd0, done},  32'd1);
    chk("bp_count", {16'd0, count}, 32'd2);
    tick();

    // Out-of-range immediate, then shift-immediate
    start = 1'b1; tick(); start = 1'b0;
    beat(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0);
    tick();
`ifdef INSTR_ENCODER_CHECK_EN
    chk("ck_bad_instr", ifa.out_instr, 32'h0000_0000);
    chk("ck_err_set",   {31'd0, err},  32'd1);
`else
    chk("ck_trunc_instr", ifa.out_instr, 32'h0000_0093);
    chk("ck_err_tied",    {31'd0, err},  32'd0);
`endif
    chk("ck_bad_addr", ifa.out_addr, 32'h0000_0000);
    beat(K_OPIMM, 3'b101, 1'b1, 5'd3, 5'd4, 5'd0, 32'd3, 1'b1);
    tick(); ifa.in_valid = 1'b0;
    chk("ck_srai_instr", ifa.out_instr, 32'h4032_5193);
    chk("ck_srai_addr",  ifa.out_addr,  32'h0000_0004);
`ifdef INSTR_ENCODER_CHECK_EN
    chk("ck_err_sticky", {31'd0, err}, 32'd1);
`endif
    tick();
    chk("ck_done", {31'd0, done}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("ck_err_clear", {31'd0, err}, 32'd0);

    // Reset mid-program with a word pending
    ifa.out_ready = 1'b0;
    beat(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    tick(); ifa.in_valid = 1'b0;
    chk("mr_valid_pre", {31'd0, ifa.out_valid}, 32'd1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("mr_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("mr_busy",  {31'd0, busy},          32'd0);
    chk("mr_done",  {31'd0, done},          32'd0);
    chk("mr_instr", ifa.out_instr,          32'h0000_0000);
    chk("mr_addr",  ifa.out_addr,           32'h0000_0000);
    ifa.out_ready = 1'b1;
    tick();
    chk("mr_no_done", {31'd0, done}, 32'd0);
    chk("mr_idle",    {31'd0, busy}, 32'd0);

    // Address wrap from BASE_ADDR 0xFFFF_FFFC
    start2 = 1'b1; tick(); start2 = 1'b0;
    ifb.in_valid = 1'b1; ifb.in_kind = K_OPIMM; ifb.in_funct3 = 3'b000; ifb.in_rd = 5'd1;
    ifb.in_imm = 32'd5; ifb.in_last = 1'b0;
    tick();
    chk("w_addr0",  ifb.out_addr,  32'hFFFF_FFFC);
    chk("w_instr0", ifb.out_instr, 32'h0050_0093);
    ifb.in_kind = K_LUI; ifb.in_rd = 5'd5; ifb.in_imm = 32'h1234_5000; ifb.in_last = 1'b1;
    tick(); ifb.in_valid = 1'b0;
    chk("w_addr1",  ifb.out_addr,  32'h0000_0000);
    chk("w_instr1", ifb.out_instr, 32'h1234_52B7);
    tick();
    chk("w_done",  {31'd0, done2},  32'd1);
    chk("w_count", {16'd0, count2}, 32'd2);
    chk("w_addr2", ifb.out_addr,    32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (instruction class, funct3, funct7b5, register indices, full 32-bit immediate) and packs them into 32-bit machine words, the inverse of the decode-stage control unit. It sits between the self-test sequencer and the instruction-memory write port, so the pipeline can be loaded with generated programs. Encoded words leave through a one-deep registered output stage with valid/ready backpressure, each tagged with an incrementing byte address.

## Interface
- `BASE_ADDR`, 32'h0000_0000: address tagged on the first word after each `start`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; arms a new program in IDLE, ignored in other states.
- `in_valid`  in  1  field beat valid.
- `in_ready`  out  1  encoder can accept a beat.
- `in_last`  in  1  beat is the final instruction of the program.
- `in_kind`  in  4  instruction class, `K_*` from the package.
- `in_funct3`  in  3  funct3 field.
- `in_funct7b5`  in  1  funct7 bit 5 (sub/sra/srai).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  32  byte offset or value, unshifted; for U-type the full 32-bit value.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  memory accepts the word.
- `out_instr`  out  32  encoded machine word.
- `out_addr`  out  32  byte address of `out_instr`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the last word is accepted.
- `err`  out  1  sticky: an illegal field was seen since `start`.
- `count`  out  16  words emitted since `start`.

## Operation
- States: IDLE, STREAM, DRAIN.
  - IDLE: on `start`, load the address counter with `BASE_ADDR`, clear `count` and `err`, go to STREAM.
  - STREAM: accept beats. A beat accepted with `in_last` moves to DRAIN.
  - DRAIN: wait for the output handshake of the last word, then pulse `done` and return to IDLE.
- `in_ready` = (state == STREAM) && (!out_valid || out_ready). `in_ready` is 0 in IDLE and in DRAIN.
- Handshake rules:
  - A transfer occurs when valid && ready in the same cycle.
  - While `out_valid` && !`out_ready`, `out_instr` and `out_addr` are held stable.
  - Once raised, `out_valid` is not dropped until the transfer completes.
- Opcodes per kind:
  - LOAD 0000011, OPIMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111.
- Formats per kind:
  - I-type: LOAD, OPIMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: AUIPC, LUI.
  - J-type: JAL.
  - R-type: OP.
- Immediate packing (R-type carries no immediate):
  - I: `imm[11:0]`→[31:20].
  - S: `imm[11:5]`→[31:25], `imm[4:0]`→[11:7].
  - B: `imm[12|10:5]`→[31|30:25], `imm[4:1|11]`→[11:8|7].
  - U: `imm[31:12]`→[31:12].
  - J: `imm[20|10:1|11|19:12]`→[31:12].
- funct7 bit 30 placement:
  - OP: `in_funct7b5` goes to bit 30 for funct3 000 and 101.
  - OPIMM: `in_funct7b5` goes to bit 30 only for funct3 101; for funct3 001/101 bits [24:20] = `imm[4:0]` and the other funct7 bits are 0.
- Address and count:
  - Each accepted output word advances the address by 4 and `count` by 1.
  - The address wraps modulo 2^32; `count` saturates at 16'hFFFF.
- `in_last` on the first beat is legal: a one-word program.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`, `in_ready`, `busy`, `done`, `err` all 0.
  - `out_instr` = 0, `out_addr` = `BASE_ADDR`, `count` = 0.
- Latency: a beat accepted at edge N presents its word with `out_valid` after edge N; 1 cycle.
- Throughput: 1 word/cycle while `out_ready` is held high.
- `done` is high for exactly the cycle after the final output transfer. `busy` falls in that same cycle.
- Simultaneous output transfer and input acceptance in one cycle: the output register reloads, `out_valid` stays 1, no bubble.
- `reset` mid-program: the in-flight word is dropped, no `done` pulse, all outputs take their reset values next cycle.
- `start` while busy: ignored.

## Configuration
- `INSTR_ENCODER_CHECK_EN` defined:
  - Fields are range-checked; an illegal field sets `err` the cycle after acceptance.
  - The offending word is emitted as 32'h0000_0000 and still consumes an address.
  - Illegal fields:
    - unknown kind;
    - I/S imm not sign-representable in 12 bits;
    - B imm outside 13 bits signed or with imm[0]=1;
    - J imm outside 21 bits signed or with imm[0]=1;
    - U imm[11:0]≠0;
    - OPIMM shift with imm[11:5]≠0.
- Not defined: no checks, out-of-range bits are silently truncated, `err` is tied to 0.

## Structure
- Package `rv_isa_pkg`: `K_*` kind codes (LOAD=0 … JAL=8), opcode constants, format enum (R/I/S/B/U/J), state enum.
- Sub-module `imm_pack`: combinational format + immediate → bit placement. `instr_encoder` holds the FSM, output register, address and count counters, and error logic.

## Test plan
- `start`, then OPIMM f3=0 rd=1 rs1=0 imm=5, `in_last` → `out_instr`=0x00500093 at `out_addr`=`BASE_ADDR`; `done` pulses one cycle after the transfer; `count`=1.
- Back-to-back stream with `out_ready` high:
  - OP f3=0 f7b5=1 rd=3 rs1=1 rs2=2 → 0x402081B3;
  - BRANCH f3=0 rs1=1 rs2=2 imm=-8 → 0xFE208CE3;
  - JAL rd=1 imm=0x800 → 0x001000EF;
  - LUI rd=5 imm=0x12345000 → 0x123452B7.
  - Required: addresses BASE+0/4/8/12, no bubbles.
- Backpressure: hold `out_ready`=0 for 3 cycles with a word pending → `out_instr` and `out_addr` stable, `in_ready`=0, nothing lost or duplicated after release.
- With `INSTR_ENCODER_CHECK_EN`: OPIMM imm=4096 → word 0x00000000, `err`=1 sticky, address still advances; a later `start` clears `err`.
- `reset` asserted in STREAM with `out_valid`=1 → next cycle `out_valid`=0, state IDLE, no `done`; `start` with BASE_ADDR=0xFFFF_FFFC gives address wrap 0xFFFF_FFFC → 0x0000_0000.
